decode_stage: RTL and testbench

//  Registered RV32I decode stage between fetch and execute. Accepts one instruction per cycle on a

---
 rtl/riscv_pkg.sv | 84 ++++++++
 rtl/decode_logic.sv | 125 ++++++++++++
 rtl/decode_stage.sv | 136 +++++++++++++
 tb/tb_decode_stage.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: RV32I opcode constants, ALU/branch operation encodings and the
// decoded-instruction record shared by decode_logic and decode_stage.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  // Branch encodings reuse the BRANCH funct3 values; 010/011 are reserved
  // funct3 codes, so they are free to mark jumps and "no transfer".
  typedef enum logic [2:0] {
    BRC_BEQ  = 3'b000,
    BRC_BNE  = 3'b001,
    BRC_JUMP = 3'b010,
    BRC_NONE = 3'b011,
    BRC_BLT  = 3'b100,
    BRC_BGE  = 3'b101,
    BRC_BLTU = 3'b110,
    BRC_BGEU = 3'b111
  } brc_op_e;

  // Decoded fields that do not depend on the stage parameters; the
  // XLEN-wide immediate and the PC/tag sideband travel beside this record.
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    alu_op_e    alu_op;
    brc_op_e    brc_op;
    logic       ch_op1;
    logic       ch_op2;
    logic       we;
    logic [1:0] mem;
    logic       illegal;
  } decoded_t;

  localparam decoded_t DECODED_RESET = '{
    rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
    alu_op: ALU_ADD, brc_op: BRC_NONE,
    ch_op1: 1'b0, ch_op2: 1'b0, we: 1'b0,
    mem: 2'b00, illegal: 1'b0
  };

  // Shared funct3 -> ALU mapping; alt selects SUB/SRA where funct7 bit 30 applies.
  function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    op = ALU_ADD;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_logic.sv
// decode_logic: purely combinational RV32I instruction decoder producing the
// decoded_t record plus an immediate sign-extended to XLEN bits.
module decode_logic
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output decoded_t        dec,
  output logic [XLEN-1:0] imm
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_raw;
  logic        illegal;
  logic        write_rd;
  logic        op_alt;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Per-opcode control, legality and immediate format selection.
  always_comb begin
    dec        = DECODED_RESET;
    dec.rs1    = instr[19:15];
    dec.rs2    = instr[24:20];
    dec.rd     = instr[11:7];
    imm_raw    = 32'd0;
    illegal    = 1'b0;
    write_rd   = 1'b0;
    op_alt     = 1'b0;
    case (opcode)
      OPC_LUI: begin
        dec.alu_op = ALU_PASSB;
        dec.ch_op2 = 1'b1;
        write_rd   = 1'b1;
        imm_raw    = {instr[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        dec.alu_op = ALU_ADD;
        dec.ch_op1 = 1'b1;
        dec.ch_op2 = 1'b1;
        write_rd   = 1'b1;
        imm_raw    = {instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        dec.alu_op = ALU_ADD;
        dec.ch_op1 = 1'b1;
        dec.ch_op2 = 1'b1;
        dec.brc_op = BRC_JUMP;
        write_rd   = 1'b1;
        imm_raw    = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OPC_JALR: begin
        dec.alu_op = ALU_ADD;
        dec.ch_op2 = 1'b1;
        dec.brc_op = BRC_JUMP;
        write_rd   = 1'b1;
        illegal    = (funct3 != 3'b000);
        imm_raw    = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_BRANCH: begin
        dec.alu_op = ALU_SUB;
        dec.brc_op = brc_op_e'(funct3);
        illegal    = (funct3[2:1] == 2'b01);
        imm_raw    = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_LOAD: begin
        dec.alu_op = ALU_ADD;
        dec.ch_op2 = 1'b1;
        dec.mem    = 2'b01;
        write_rd   = 1'b1;
        illegal    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        imm_raw    = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_STORE: begin
        dec.alu_op = ALU_ADD;
        dec.ch_op2 = 1'b1;
        dec.mem    = 2'b10;
        illegal    = funct3[2] || (funct3 == 3'b011);
        imm_raw    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_OPIMM: begin
        dec.ch_op2 = 1'b1;
        write_rd   = 1'b1;
        imm_raw    = {{20{instr[31]}}, instr[31:20]};
        case (funct3)
          3'b001: begin
            dec.alu_op = ALU_SLL;
            illegal    = (funct7 != F7_BASE);
          end
          3'b101: begin
            dec.alu_op = instr[30] ? ALU_SRA : ALU_SRL;
            illegal    = (funct7 != F7_BASE) && (funct7 != F7_ALT);
          end
          default: dec.alu_op = alu_from_funct3(funct3, 1'b0);
        endcase
      end
      OPC_OP: begin
        write_rd   = 1'b1;
        op_alt     = (funct7 == F7_ALT);
        illegal    = !((funct7 == F7_BASE) ||
                       (op_alt && ((funct3 == 3'b000) || (funct3 == 3'b101))));
        dec.alu_op = alu_from_funct3(funct3, op_alt);
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      dec.alu_op = ALU_ADD;
      dec.brc_op = BRC_NONE;
      dec.ch_op1 = 1'b0;
      dec.ch_op2 = 1'b0;
      dec.mem    = 2'b00;
      imm_raw    = 32'd0;
    end
    dec.illegal = illegal;
    dec.we      = write_rd && (instr[11:7] != 5'd0) && !illegal;
  end

  assign imm = XLEN'($signed(imm_raw));

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode stage with a 2-entry skid buffer
// (main register M drives the outputs, skid register S absorbs one extra
// entry so in_ready can be a registered signal). Optional performance
// counters are enabled by defining DECODE_PERF_CNT_EN.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [TAG_W-1:0] out_tag,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [XLEN-1:0]  out_imm,
  output logic [3:0]       out_alu_op,
  output logic [2:0]       out_brc_op,
  output logic             out_ch_op1,
  output logic             out_ch_op2,
  output logic             out_we,
  output logic [1:0]       out_mem,
  output logic             out_illegal
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [31:0]      cnt_instr,
  output logic [31:0]      cnt_illegal
`endif
);

  typedef struct packed {
    decoded_t               dec;
    logic [XLEN-1:0]        imm;
    logic [PC_W-1:0]        pc;
    logic [TAG_W-1:0]       tag;
  } entry_t;

  localparam entry_t ENTRY_RESET = '{dec: DECODED_RESET, imm: '0, pc: '0, tag: '0};

  decoded_t        dec_w;
  logic [XLEN-1:0] imm_w;
  entry_t          new_entry;
  entry_t          m_entry;
  entry_t          s_entry;
  logic            m_valid;
  logic            s_valid;
  logic            in_fire;
  logic            out_fire;

  decode_logic #(.XLEN(XLEN)) u_decode (
    .instr (in_instr),
    .dec   (dec_w),
    .imm   (imm_w)
  );

  assign new_entry = {dec_w, imm_w, in_pc, in_tag};

  // in_ready comes straight from the skid-full flop, so it never depends on out_ready.
  assign in_ready  = !s_valid;
  assign out_valid = m_valid;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = m_valid && out_ready;

  // Skid buffer: flush wins over any handshake; S refills M on an out-accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_entry <= ENTRY_RESET;
      s_entry <= ENTRY_RESET;
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (flush) begin
      m_entry <= ENTRY_RESET;
      s_entry <= ENTRY_RESET;
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (out_fire) begin
      if (s_valid) begin
        m_entry <= s_entry;
        s_valid <= 1'b0;
      end else if (in_fire) begin
        m_entry <= new_entry;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (in_fire) begin
      if (m_valid) begin
        s_entry <= new_entry;
        s_valid <= 1'b1;
      end else begin
        m_entry <= new_entry;
        m_valid <= 1'b1;
      end
    end
  end

  assign out_pc      = m_entry.pc;
  assign out_tag     = m_entry.tag;
  assign out_rs1     = m_entry.dec.rs1;
  assign out_rs2     = m_entry.dec.rs2;
  assign out_rd      = m_entry.dec.rd;
  assign out_imm     = m_entry.imm;
  assign out_alu_op  = m_entry.dec.alu_op;
  assign out_brc_op  = m_entry.dec.brc_op;
  assign out_ch_op1  = m_entry.dec.ch_op1;
  assign out_ch_op2  = m_entry.dec.ch_op2;
  assign out_we      = m_entry.dec.we;
  assign out_mem     = m_entry.dec.mem;
  assign out_illegal = m_entry.dec.illegal;

`ifdef DECODE_PERF_CNT_EN
  // Count out-accepts (and illegal ones) that are not cancelled by flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_instr   <= 32'd0;
      cnt_illegal <= 32'd0;
    end else if (out_fire && !flush) begin
      cnt_instr <= cnt_instr + 32'd1;
      if (m_entry.dec.illegal) begin
        cnt_illegal <= cnt_illegal + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against a
// queue-based reference model that decodes from the RV32I encoding rules.
module tb_decode_stage;

  localparam int XLEN  = 32;
  localparam int PC_W  = 32;
  localparam int TAG_W = 4;
  localparam int ALU_TAB [8] = '{0, 2, 3, 4, 5, 6, 8, 9};

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_instr = 32'd0;
  logic [PC_W-1:0]  in_pc = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [PC_W-1:0]  out_pc;
  logic [TAG_W-1:0] out_tag;
  logic [4:0]       out_rs1, out_rs2, out_rd;
  logic [XLEN-1:0]  out_imm;
  logic [3:0]       out_alu_op;
  logic [2:0]       out_brc_op;
  logic             out_ch_op1, out_ch_op2, out_we, out_illegal;
  logic [1:0]       out_mem;
`ifdef DECODE_PERF_CNT_EN
  logic [31:0]      cnt_instr, cnt_illegal;
`endif

  typedef struct {
    logic [4:0]       rs1, rs2, rd;
    logic [XLEN-1:0]  imm;
    logic [3:0]       alu;
    logic [2:0]       brc;
    logic             op1, op2, we, ill;
    logic [1:0]       mem;
    logic [PC_W-1:0]  pc;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t model_q[$];
  int   pass_cnt = 0;
  int   fail_cnt = 0;
  int   check_cnt = 0;
  int   cnt_instr_model = 0;
  int   cnt_illegal_model = 0;
  int   pc_seq = 32'h1000;

  decode_stage #(.XLEN(XLEN), .PC_W(PC_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_tag(out_tag),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_alu_op(out_alu_op), .out_brc_op(out_brc_op),
    .out_ch_op1(out_ch_op1), .out_ch_op2(out_ch_op2), .out_we(out_we),
    .out_mem(out_mem), .out_illegal(out_illegal)
`ifdef DECODE_PERF_CNT_EN
    , .cnt_instr(cnt_instr), .cnt_illegal(cnt_illegal)
`endif
  );

  always #5 clk = ~clk;

  // Instruction encoders
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input int imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    logic [11:0] i;
    i = imm[11:0];
    return {i, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    logic [12:0] b;
    b = imm[12:0];
    return {b[12], b[10:5], rs2, rs1, f3, b[4:1], b[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input logic [4:0] rd);
    logic [20:0] j;
    j = imm[20:0];
    return {j[20], j[10:1], j[11], j[19:12], rd, 7'h6F};
  endfunction

  // Reference decoder written from the instruction-set rules
  function automatic exp_t ref_decode(input logic [31:0] w, input logic [PC_W-1:0] pc,
                                      input logic [TAG_W-1:0] tag);
    exp_t e;
    int op, f3, f7, imm_i, imm_s, imm_b, imm_j, imm_u, imm_sel;
    bit writes;
    op = int'(w[6:0]);
    f3 = int'(w[14:12]);
    f7 = int'(w[31:25]);
    imm_i = $signed(w) >>> 20;
    imm_s = (imm_i & ~31) | int'(w[11:7]);
    imm_b = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
    imm_j = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
    imm_u = int'(w & 32'hFFFFF000);
    e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
    e.pc = pc; e.tag = tag;
    e.alu = 4'd0; e.brc = 3'd3; e.op1 = 1'b0; e.op2 = 1'b0; e.mem = 2'd0; e.ill = 1'b0;
    imm_sel = 0;
    writes = 1'b0;
    case (op)
      'h37: begin imm_sel = imm_u; e.alu = 4'd10; e.op2 = 1'b1; writes = 1'b1; end
      'h17: begin imm_sel = imm_u; e.op1 = 1'b1; e.op2 = 1'b1; writes = 1'b1; end
      'h6F: begin imm_sel = imm_j; e.op1 = 1'b1; e.op2 = 1'b1; e.brc = 3'd2; writes = 1'b1; end
      'h67: begin imm_sel = imm_i; e.op2 = 1'b1; e.brc = 3'd2; writes = 1'b1; e.ill = (f3 != 0); end
      'h63: begin imm_sel = imm_b; e.alu = 4'd1; e.brc = 3'(f3); e.ill = (f3 == 2 || f3 == 3); end
      'h03: begin imm_sel = imm_i; e.op2 = 1'b1; e.mem = 2'd1; writes = 1'b1;
                  e.ill = (f3 == 3 || f3 == 6 || f3 == 7); end
      'h23: begin imm_sel = imm_s; e.op2 = 1'b1; e.mem = 2'd2; e.ill = (f3 > 2); end
      'h13: begin
        imm_sel = imm_i; e.op2 = 1'b1; writes = 1'b1; e.alu = 4'(ALU_TAB[f3]);
        if (f3 == 1) e.ill = (f7 != 0);
        if (f3 == 5) begin
          if (f7 == 32) e.alu = 4'd7;
          else e.ill = (f7 != 0);
        end
      end
      'h33: begin
        writes = 1'b1;
        if (f7 == 0) e.alu = 4'(ALU_TAB[f3]);
        else if (f7 == 32 && f3 == 0) e.alu = 4'd1;
        else if (f7 == 32 && f3 == 5) e.alu = 4'd7;
        else e.ill = 1'b1;
      end
      default: e.ill = 1'b1;
    endcase
    e.imm = XLEN'(imm_sel);
    if (e.ill) begin
      e.brc = 3'd3;
      e.mem = 2'd0;
    end
    e.we = writes && (w[11:7] != 5'd0) && !e.ill;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    check_cnt++;
    assert (observed === expected) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic compareDut(input string name);
    checkOutput({name, ".out_valid"}, 64'(out_valid), 64'(model_q.size() > 0));
    checkOutput({name, ".in_ready"}, 64'(in_ready), 64'(model_q.size() < 2));
    if (model_q.size() > 0) begin
      checkOutput({name, ".pc"}, 64'(out_pc), 64'(model_q[0].pc));
      checkOutput({name, ".tag"}, 64'(out_tag), 64'(model_q[0].tag));
      checkOutput({name, ".illegal"}, 64'(out_illegal), 64'(model_q[0].ill));
      checkOutput({name, ".we"}, 64'(out_we), 64'(model_q[0].we));
      checkOutput({name, ".mem"}, 64'(out_mem), 64'(model_q[0].mem));
      checkOutput({name, ".brc"}, 64'(out_brc_op), 64'(model_q[0].brc));
      if (!model_q[0].ill) begin
        checkOutput({name, ".rs1"}, 64'(out_rs1), 64'(model_q[0].rs1));
        checkOutput({name, ".rs2"}, 64'(out_rs2), 64'(model_q[0].rs2));
        checkOutput({name, ".rd"}, 64'(out_rd), 64'(model_q[0].rd));
        checkOutput({name, ".imm"}, 64'(out_imm), 64'(model_q[0].imm));
        checkOutput({name, ".alu"}, 64'(out_alu_op), 64'(model_q[0].alu));
        checkOutput({name, ".ch_op1"}, 64'(out_ch_op1), 64'(model_q[0].op1));
        checkOutput({name, ".ch_op2"}, 64'(out_ch_op2), 64'(model_q[0].op2));
      end
    end
`ifdef DECODE_PERF_CNT_EN
    checkOutput({name, ".cnt_instr"}, 64'(cnt_instr), 64'(32'(cnt_instr_model)));
    checkOutput({name, ".cnt_illegal"}, 64'(cnt_illegal), 64'(32'(cnt_illegal_model)));
`endif
  endtask

  // One clock: drive at negedge, advance the model at posedge, compare at next negedge
  task automatic applyStimulus(input string name, input logic v, input logic [31:0] instr,
                               input logic ordy, input logic fl);
    logic [PC_W-1:0]  pc;
    logic [TAG_W-1:0] tag;
    bit do_out, do_in;
    pc = PC_W'(pc_seq);
    tag = TAG_W'($urandom);
    pc_seq += 4;
    in_valid = v; in_instr = instr; in_pc = pc; in_tag = tag;
    out_ready = ordy; flush = fl;
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      do_out = (model_q.size() > 0) && ordy;
      do_in = v && (model_q.size() < 2);
      if (do_out) begin
        cnt_instr_model++;
        if (model_q[0].ill) cnt_illegal_model++;
        void'(model_q.pop_front());
      end
      if (do_in) model_q.push_back(ref_decode(instr, pc, tag));
    end
    @(negedge clk);
    compareDut(name);
  endtask

  function automatic logic [31:0] random_instr();
    logic [31:0] w;
    int k;
    logic [6:0] ops [9];
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    w = $urandom;
    k = $urandom_range(0, 9);
    if (k < 9) begin
      w[6:0] = ops[k];
      if ((k == 7 || k == 8) && $urandom_range(0, 3) != 0)
        w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      if ((k == 3 || k == 4) && $urandom_range(0, 1) == 1)
        w[14:12] = 3'b000;
    end
    return w;
  endfunction

  initial begin
    int fed;
    logic [31:0] stream [4];
    logic [31:0] instr;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset.out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset.in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset.brc", 64'(out_brc_op), 64'd3);
    checkOutput("reset.imm", 64'(out_imm), 64'd0);
    checkOutput("reset.we", 64'(out_we), 64'd0);
    checkOutput("reset.alu", 64'(out_alu_op), 64'd0);
    checkOutput("reset.illegal", 64'(out_illegal), 64'd0);
    checkOutput("reset.mem", 64'(out_mem), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // ADD x31,x5,x4 with one-cycle latency
    applyStimulus("add", 1'b1, enc_r(7'h00, 5'd4, 5'd5, 3'b000, 5'd31), 1'b1, 1'b0);
    checkOutput("add.latency", 64'(out_valid), 64'd1);
    checkOutput("add.rs1_const", 64'(out_rs1), 64'd5);
    checkOutput("add.rs2_const", 64'(out_rs2), 64'd4);
    checkOutput("add.rd_const", 64'(out_rd), 64'd31);
    checkOutput("add.alu_const", 64'(out_alu_op), 64'd0);
    checkOutput("add.we_const", 64'(out_we), 64'd1);
    applyStimulus("add.drain", 1'b0, 32'd0, 1'b1, 1'b0);

    // ORI x1,x15,1
    applyStimulus("ori", 1'b1, enc_i(1, 5'd15, 3'b110, 5'd1, 7'h13), 1'b0, 1'b0);
    checkOutput("ori.imm_const", 64'(out_imm), 64'd1);
    checkOutput("ori.alu_const", 64'(out_alu_op), 64'd8);
    checkOutput("ori.ch_op2_const", 64'(out_ch_op2), 64'd1);
    applyStimulus("ori.drain", 1'b0, 32'd0, 1'b1, 1'b0);

    // BNE x13,x31,-16
    applyStimulus("bne", 1'b1, enc_b(-16, 5'd31, 5'd13, 3'b001), 1'b0, 1'b0);
    checkOutput("bne.imm_const", 64'(out_imm), 64'hFFFF_FFF0);
    checkOutput("bne.brc_const", 64'(out_brc_op), 64'd1);
    checkOutput("bne.we_const", 64'(out_we), 64'd0);
    applyStimulus("bne.drain", 1'b0, 32'd0, 1'b1, 1'b0);

    // JAL x10,-16
    applyStimulus("jal", 1'b1, enc_j(-16, 5'd10), 1'b0, 1'b0);
    checkOutput("jal.imm_const", 64'(out_imm), 64'hFFFF_FFF0);
    checkOutput("jal.ch_op1_const", 64'(out_ch_op1), 64'd1);
    checkOutput("jal.brc_const", 64'(out_brc_op), 64'd2);
    applyStimulus("jal.drain", 1'b0, 32'd0, 1'b1, 1'b0);

    // Stream four instructions against three stalled cycles
    stream = '{enc_i(5, 5'd1, 3'b000, 5'd2, 7'h13), enc_r(7'h20, 5'd3, 5'd4, 3'b000, 5'd5),
               enc_i(-8, 5'd6, 3'b010, 5'd7, 7'h03), enc_b(32, 5'd8, 5'd9, 3'b100)};
    fed = 0;
    for (int cyc = 0; cyc < 20 && (fed < 4 || model_q.size() > 0); cyc++) begin
      if (fed < 4) begin
        instr = stream[fed];
        if (model_q.size() < 2 || (cyc >= 3 && model_q.size() < 3)) begin
          if (model_q.size() < 2) fed++;
        end
        applyStimulus("stream", 1'b1, instr, (cyc >= 3), 1'b0);
      end else begin
        applyStimulus("stream", 1'b0, 32'd0, 1'b1, 1'b0);
      end
      if (cyc == 1) checkOutput("stream.in_ready_low", 64'(in_ready), 64'd0);
    end
    checkOutput("stream.all_fed", 64'(fed), 64'd4);
    checkOutput("stream.drained", 64'(out_valid), 64'd0);

    // Flush with two buffered entries and a simultaneous input
    applyStimulus("fill", 1'b1, enc_i(3, 5'd2, 3'b100, 5'd3, 7'h13), 1'b0, 1'b0);
    applyStimulus("fill", 1'b1, enc_r(7'h00, 5'd2, 5'd3, 3'b111, 5'd4), 1'b0, 1'b0);
    applyStimulus("flush", 1'b1, enc_r(7'h00, 5'd1, 5'd1, 3'b001, 5'd1), 1'b1, 1'b1);
    checkOutput("flush.out_valid", 64'(out_valid), 64'd0);
    checkOutput("flush.in_ready", 64'(in_ready), 64'd1);
    applyStimulus("flush.after", 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("flush.none_emitted", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-operation
    applyStimulus("prereset", 1'b1, enc_i(9, 5'd4, 3'b000, 5'd4, 7'h13), 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    model_q.delete();
    cnt_instr_model = 0;
    cnt_illegal_model = 0;
    #1;
    checkOutput("midreset.out_valid", 64'(out_valid), 64'd0);
    checkOutput("midreset.in_ready", 64'(in_ready), 64'd1);
    checkOutput("midreset.brc", 64'(out_brc_op), 64'd3);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Illegal opcode and bad OP funct7
    applyStimulus("ill_opc", 1'b1, 32'h0000_007F, 1'b0, 1'b0);
    checkOutput("ill_opc.illegal_const", 64'(out_illegal), 64'd1);
    checkOutput("ill_opc.we_const", 64'(out_we), 64'd0);
    applyStimulus("ill_f7", 1'b1, enc_r(7'h01, 5'd2, 5'd3, 3'b000, 5'd4), 1'b1, 1'b0);
    checkOutput("ill_f7.illegal_const", 64'(out_illegal), 64'd1);
    checkOutput("ill_f7.we_const", 64'(out_we), 64'd0);
    applyStimulus("ill.drain", 1'b0, 32'd0, 1'b1, 1'b0);
`ifdef DECODE_PERF_CNT_EN
    checkOutput("perf.cnt_illegal_const", 64'(cnt_illegal), 64'd2);
    checkOutput("perf.cnt_instr_const", 64'(cnt_instr), 64'd2);
`endif

    // Randomized traffic with random stalls and occasional flush
    for (int n = 0; n < 400; n++) begin
      applyStimulus("rand", ($urandom_range(0, 3) != 0), random_instr(),
                    ($urandom_range(0, 2) != 0), ($urandom_range(0, 31) == 0));
    end

    if (fail_cnt != 0) $display("[TB] %0d comparisons did not match", fail_cnt);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
